// File: rtl/axil_cfg_router.sv
// AXI4-Lite slave for the FSIC config window; routes each access to one cfg-bus region.
// Optional timeout: define AXIL_CFG_ROUTER_TIMEOUT_EN.
module axil_cfg_router #(
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        sys_clock,
    input  logic        sys_reset,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        cfg_req_valid,
    input  logic        cfg_req_ready,
    output logic        cfg_req_we,
    output logic [3:0]  cfg_req_sel,
    output logic [11:0] cfg_req_offset,
    output logic [31:0] cfg_req_wdata,
    output logic [3:0]  cfg_req_wstrb,
    input  logic        cfg_rsp_valid,
    input  logic [31:0] cfg_rsp_rdata,
    input  logic        cfg_rsp_err,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        aw_held, w_held;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;
    logic        rd_next, is_wr;

    logic        idle, aw_ok, w_ok, wr_req, rd_avail, rd_req;
    logic        grant_wr, grant_rd, grant;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb, dec_sel;
    logic        dec_err, tmo_hit, tmo_fire, rsp_take, resp_done;
    logic        unused_bits;

    assign unused_bits = &{1'b0, s_awaddr[1:0], s_araddr[1:0]};

    // Ready outputs are forced low while reset is held.
    assign idle      = (state == IDLE) && !sys_reset;
    assign s_awready = idle && !aw_held;
    assign s_wready  = idle && !w_held;
    assign aw_ok     = aw_held || (s_awvalid && s_awready);
    assign w_ok      = w_held || (s_wvalid && s_wready);
    assign wr_req    = idle && aw_ok && w_ok;
    assign rd_avail  = idle && !aw_held && !w_held;
    assign rd_req    = rd_avail && s_arvalid;
    assign grant_wr  = wr_req && (!rd_req || !rd_next);
    assign grant_rd  = rd_req && !grant_wr;
    assign grant     = grant_wr || grant_rd;
    assign s_arready = rd_avail && !grant_wr;

    assign g_addr  = grant_wr ? (aw_held ? aw_addr : s_awaddr) : s_araddr;
    assign g_wdata = w_held ? w_data : s_wdata;
    assign g_wstrb = w_held ? w_strb : s_wstrb;
    assign dec_sel = (g_addr[15:8] == 8'h21) ? 4'd8 : g_addr[15:12];
    assign dec_err = (g_addr[31:16] != BASE_ADDR[31:16]) ||
                     ((g_addr[15:8] != 8'h21) && g_addr[15]);

`ifdef AXIL_CFG_ROUTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    assign tmo_hit     = (tmo_cnt == 16'(TIMEOUT_CYC - 1));
    assign err_timeout = err_q;

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_fire;
            if (grant && !dec_err)
                tmo_cnt <= '0;
            else if (state == ISSUE || state == WAIT)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clock) begin
        if (sys_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmo_fire  = 1'b0;
        rsp_take  = 1'b0;
        resp_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant)
                    state_nxt = dec_err ? RESP : ISSUE;
            end
            ISSUE: begin
                if (cfg_req_ready) begin
                    rsp_take  = cfg_rsp_valid;
                    state_nxt = cfg_rsp_valid ? RESP : WAIT;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                if (cfg_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_done = is_wr ? s_bready : s_rready;
                if (resp_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_addr        <= '0;
            w_data         <= '0;
            w_strb         <= '0;
            rd_next        <= 1'b1;
            is_wr          <= 1'b0;
            s_bresp        <= 2'b00;
            s_bvalid       <= 1'b0;
            s_rresp        <= 2'b00;
            s_rdata        <= '0;
            s_rvalid       <= 1'b0;
            cfg_req_valid  <= 1'b0;
            cfg_req_we     <= 1'b0;
            cfg_req_sel    <= '0;
            cfg_req_offset <= '0;
            cfg_req_wdata  <= '0;
            cfg_req_wstrb  <= '0;
        end else begin
            if (s_awvalid && s_awready && !grant_wr) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready && !grant_wr) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
            if (grant_wr) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (grant) begin
                rd_next <= !rd_next;
                is_wr   <= grant_wr;
                if (dec_err) begin
                    if (grant_wr) begin
                        s_bvalid <= 1'b1;
                        s_bresp  <= 2'b11;
                    end else begin
                        s_rvalid <= 1'b1;
                        s_rresp  <= 2'b11;
                        s_rdata  <= '0;
                    end
                end else begin
                    cfg_req_valid  <= 1'b1;
                    cfg_req_we     <= grant_wr;
                    cfg_req_sel    <= dec_sel;
                    cfg_req_offset <= {g_addr[11:2], 2'b00};
                    cfg_req_wdata  <= grant_wr ? g_wdata : '0;
                    cfg_req_wstrb  <= grant_wr ? g_wstrb : '0;
                end
            end
            if (state == ISSUE && (cfg_req_ready || tmo_fire))
                cfg_req_valid <= 1'b0;
            if (rsp_take) begin
                if (is_wr) begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= cfg_rsp_err ? 2'b10 : 2'b00;
                end else begin
                    s_rvalid <= 1'b1;
                    s_rresp  <= cfg_rsp_err ? 2'b10 : 2'b00;
                    s_rdata  <= cfg_rsp_rdata;
                end
            end
            if (tmo_fire) begin
                if (is_wr) begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= 2'b10;
                end else begin
                    s_rvalid <= 1'b1;
                    s_rresp  <= 2'b10;
                    s_rdata  <= 32'hFFFF_FFFF;
                end
            end
            if (resp_done) begin
                s_bvalid <= 1'b0;
                s_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_cfg_router.sv
// Directed bench for axil_cfg_router: decode, latency, arbitration, reset.
module tb_axil_cfg_router;

    logic        sys_clock, sys_reset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rvalid, s_rready;
    logic        cfg_req_valid, cfg_req_ready, cfg_req_we;
    logic [3:0]  cfg_req_sel, cfg_req_wstrb;
    logic [11:0] cfg_req_offset;
    logic [31:0] cfg_req_wdata, cfg_rsp_rdata;
    logic        cfg_rsp_valid, cfg_rsp_err, err_timeout;

    int checks = 0;
    int failures = 0;
    bit ptr_rd;

    axil_cfg_router #(.TIMEOUT_CYC(16)) dut (
        .sys_clock(sys_clock), .sys_reset(sys_reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
        .cfg_req_we(cfg_req_we), .cfg_req_sel(cfg_req_sel),
        .cfg_req_offset(cfg_req_offset), .cfg_req_wdata(cfg_req_wdata),
        .cfg_req_wstrb(cfg_req_wstrb),
        .cfg_rsp_valid(cfg_rsp_valid), .cfg_rsp_rdata(cfg_rsp_rdata),
        .cfg_rsp_err(cfg_rsp_err), .err_timeout(err_timeout)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    // Complete an issued request with ready and response in one cycle.
    task automatic serve(input bit we, input logic [31:0] rd,
                         input bit err, input logic [31:0] exp_wdata);
        chk("req_valid", {31'd0, cfg_req_valid}, 1);
        chk("req_we", {31'd0, cfg_req_we}, {31'd0, we});
        if (we) chk("req_wdata", cfg_req_wdata, exp_wdata);
        cfg_req_ready = 1; cfg_rsp_valid = 1;
        cfg_rsp_rdata = rd; cfg_rsp_err = err;
        tick();
        cfg_req_ready = 0; cfg_rsp_valid = 0; cfg_rsp_err = 0;
        chk("req_drop", {31'd0, cfg_req_valid}, 0);
        if (we) begin
            chk("bvalid", {31'd0, s_bvalid}, 1);
            chk("bresp", {30'd0, s_bresp}, err ? 2 : 0);
            s_bready = 1; tick(); s_bready = 0;
            chk("bvalid_clr", {31'd0, s_bvalid}, 0);
        end else begin
            chk("rvalid", {31'd0, s_rvalid}, 1);
            chk("rresp", {30'd0, s_rresp}, err ? 2 : 0);
            chk("rdata", s_rdata, rd);
            s_rready = 1; tick(); s_rready = 0;
            chk("rvalid_clr", {31'd0, s_rvalid}, 0);
        end
    endtask

    task automatic decerr_read(input logic [31:0] a);
        s_araddr = a; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("dec_noreq", {31'd0, cfg_req_valid}, 0);
        chk("dec_rvalid", {31'd0, s_rvalid}, 1);
        chk("dec_rresp", {30'd0, s_rresp}, 3);
        chk("dec_rdata", s_rdata, 0);
        s_rready = 1; tick(); s_rready = 0;
    endtask

    initial begin
        sys_reset = 1;
        s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0;
        s_wvalid = 0; s_bready = 0; s_araddr = 0; s_arvalid = 0;
        s_rready = 0; cfg_req_ready = 0; cfg_rsp_valid = 0;
        cfg_rsp_rdata = 0; cfg_rsp_err = 0;
        tick(); tick();
        chk("rst_ready", {29'd0, s_awready, s_wready, s_arready}, 0);
        chk("rst_valid", {29'd0, s_bvalid, s_rvalid, cfg_req_valid}, 0);
        chk("rst_resp", {28'd0, s_bresp, s_rresp}, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_req", {cfg_req_wdata[15:0], cfg_req_offset, cfg_req_sel}, 0);
        chk("rst_tmo", {31'd0, err_timeout}, 0);
        sys_reset = 0;
        tick();
        chk("idle_ready", {29'd0, s_awready, s_wready, s_arready}, 3'b111);

        // Read sel 5 with a 3-cycle target response.
        s_araddr = 32'h6000_5000; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("rd5_valid", {31'd0, cfg_req_valid}, 1);
        chk("rd5_sel", {28'd0, cfg_req_sel}, 5);
        chk("rd5_off", {20'd0, cfg_req_offset}, 0);
        chk("rd5_we", {31'd0, cfg_req_we}, 0);
        cfg_req_ready = 1;
        tick();
        cfg_req_ready = 0;
        chk("rd5_drop", {31'd0, cfg_req_valid}, 0);
        tick(); tick();
        chk("rd5_wait", {31'd0, s_rvalid}, 0);
        cfg_rsp_valid = 1; cfg_rsp_rdata = 32'h1F;
        tick();
        cfg_rsp_valid = 0;
        chk("rd5_rvalid", {31'd0, s_rvalid}, 1);
        chk("rd5_rdata", s_rdata, 32'h1F);
        chk("rd5_rresp", {30'd0, s_rresp}, 0);
        s_rready = 1; tick(); s_rready = 0;

        // Minimum latency: rvalid two cycles after AR.
        s_araddr = 32'h6000_0010; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("lat_off", {20'd0, cfg_req_offset}, 12'h010);
        serve(0, 32'hA5, 0, 0);

        // W two cycles ahead of AW.
        s_wdata = 3; s_wstrb = 4'hF; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        chk("w_only_arrdy", {31'd0, s_arready}, 0);
        tick();
        chk("w_only_noreq", {31'd0, cfg_req_valid}, 0);
        s_awaddr = 32'h6000_7000; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        chk("wr7_sel", {28'd0, cfg_req_sel}, 7);
        chk("wr7_strb", {28'd0, cfg_req_wstrb}, 4'hF);
        serve(1, 0, 0, 3);
        chk("wr7_nodup", {31'd0, cfg_req_valid}, 0);

        decerr_read(32'h6000_9000);
        decerr_read(32'h5000_5000);

        s_araddr = 32'h6000_2104; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("mb_sel", {28'd0, cfg_req_sel}, 8);
        chk("mb_off", {20'd0, cfg_req_offset}, 12'h104);
        serve(0, 32'h0, 0, 0);

        // Six grants so far: pointer is back to read-next.
        ptr_rd = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                decerr_read(32'h6000_F000);
                ptr_rd = !ptr_rd;
            end
            s_awaddr = 32'h6000_3000 + 32'(i * 4); s_awvalid = 1;
            s_wdata = 32'h50 + 32'(i); s_wstrb = 4'h3; s_wvalid = 1;
            s_araddr = 32'h6000_4000 + 32'(i * 4); s_arvalid = 1;
            tick();
            s_awvalid = 0; s_wvalid = 0;
            if (ptr_rd) begin
                s_arvalid = 0;
                serve(0, 32'h100 + 32'(i), i == 2, 0);
                tick();
                serve(1, 0, 0, 32'h50 + 32'(i));
            end else begin
                serve(1, 0, 0, 32'h50 + 32'(i));
                tick();
                s_arvalid = 0;
                serve(0, 32'h100 + 32'(i), i == 2, 0);
            end
            ptr_rd = !ptr_rd;
            ptr_rd = !ptr_rd;
        end

`ifdef AXIL_CFG_ROUTER_TIMEOUT_EN
        s_araddr = 32'h6000_1000; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        for (int k = 0; k < 15; k++) tick();
        chk("tmo_pending", {31'd0, cfg_req_valid}, 1);
        tick();
        chk("tmo_pulse", {31'd0, err_timeout}, 1);
        chk("tmo_drop", {31'd0, cfg_req_valid}, 0);
        chk("tmo_rresp", {30'd0, s_rresp}, 2);
        chk("tmo_rdata", s_rdata, 32'hFFFF_FFFF);
        cfg_rsp_valid = 1; cfg_rsp_rdata = 32'h77;
        tick();
        cfg_rsp_valid = 0;
        chk("tmo_pulse_end", {31'd0, err_timeout}, 0);
        chk("tmo_late", s_rdata, 32'hFFFF_FFFF);
        s_rready = 1; tick(); s_rready = 0;
        s_araddr = 32'h6000_1004; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        serve(0, 32'h99, 0, 0);
`endif

        // Reset while waiting for a response.
        s_araddr = 32'h6000_1000; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        cfg_req_ready = 1;
        tick();
        cfg_req_ready = 0;
        sys_reset = 1;
        tick();
        chk("mid_rst_valid", {29'd0, s_bvalid, s_rvalid, cfg_req_valid}, 0);
        chk("mid_rst_rdata", s_rdata, 0);
        chk("mid_rst_ready", {29'd0, s_awready, s_wready, s_arready}, 0);
        sys_reset = 0;
        cfg_rsp_valid = 1; cfg_rsp_rdata = 32'hDEAD;
        tick();
        cfg_rsp_valid = 0;
        chk("late_rsp", {30'd0, s_bvalid, s_rvalid}, 0);
        s_awaddr = 32'h6000_5000; s_awvalid = 1;
        s_wdata = 32'hCAFE; s_wstrb = 4'h0; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        chk("post_sel", {28'd0, cfg_req_sel}, 5);
        chk("post_strb", {28'd0, cfg_req_wstrb}, 0);
        serve(1, 0, 0, 32'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
